// File: rtl/light_pattern_seq.sv
// Timed lamp-channel sequencer driving the 3-bit select of the light-stand multiplexer.
// Define LIGHT_SEQ_BOUNCE_EN for ping-pong stepping; otherwise the select wraps at the end channels.
module light_pattern_seq #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_clear,
  input  logic       i_dir,
  output logic [2:0] o_select,
  output logic       o_tick,
  output logic       o_busy
);

  localparam int            PW   = $clog2(CLK_DIV);
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] presc, presc_n;
  logic          dir, dir_n;
  logic [2:0]    select_n;
  logic          tick_n;
  logic [2:0]    adv_select;
  logic          adv_dir;

  // Channel that follows the current one, and the direction to use after it.
  always_comb begin
    adv_select = o_select;
    adv_dir    = dir;
`ifdef LIGHT_SEQ_BOUNCE_EN
    if (!dir) begin
      if (o_select == 3'd4) begin
        adv_select = 3'd3;
        adv_dir    = 1'b1;
      end else begin
        adv_select = o_select + 3'd1;
      end
    end else begin
      if (o_select == 3'd1) begin
        adv_select = 3'd2;
        adv_dir    = 1'b0;
      end else begin
        adv_select = o_select - 3'd1;
      end
    end
`else
    if (!dir) adv_select = (o_select == 3'd4) ? 3'd1 : o_select + 3'd1;
    else      adv_select = (o_select == 3'd1) ? 3'd4 : o_select - 3'd1;
`endif
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    state_n  = state;
    select_n = o_select;
    presc_n  = presc;
    dir_n    = dir;
    tick_n   = 1'b0;
    case (state)
      IDLE: begin
        select_n = 3'd0;
        presc_n  = '0;
        if (i_start) begin
          state_n  = RUN;
          dir_n    = i_dir;
          select_n = i_dir ? 3'd4 : 3'd1;
        end
      end
      RUN: begin
        if (i_clear) begin
          state_n  = IDLE;
          select_n = 3'd0;
          presc_n  = '0;
        end else if (i_stop) begin
          // The stop cycle is still RUN time, but it may never complete a step.
          state_n = HOLD;
          if (presc != LAST) presc_n = presc + 1'b1;
        end else if (presc == LAST) begin
          presc_n  = '0;
          select_n = adv_select;
          dir_n    = adv_dir;
          tick_n   = 1'b1;
        end else begin
          presc_n = presc + 1'b1;
        end
      end
      HOLD: begin
        if (i_clear) begin
          state_n  = IDLE;
          select_n = 3'd0;
          presc_n  = '0;
        end else if (i_start) begin
          state_n = RUN;
        end
      end
      default: begin
        state_n  = IDLE;
        select_n = 3'd0;
        presc_n  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (i_reset) begin
      state    <= IDLE;
      o_select <= 3'd0;
      o_tick   <= 1'b0;
      o_busy   <= 1'b0;
      presc    <= '0;
      dir      <= 1'b0;
    end else begin
      state    <= state_n;
      o_select <= select_n;
      o_tick   <= tick_n;
      o_busy   <= (state_n != IDLE);
      presc    <= presc_n;
      dir      <= dir_n;
    end
  end

endmodule

// File: tb/tb_light_pattern_seq.sv
// Self-checking bench for light_pattern_seq: directed scenarios plus random control pulses,
// compared every cycle against a step-count/elapsed-time reference model.
module tb_light_pattern_seq;

  localparam int CLK_DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_HOLD = 2;

`ifdef LIGHT_SEQ_BOUNCE_EN
  localparam int SEQ_LEN = 6;
  int asc_seq  [SEQ_LEN] = '{1, 2, 3, 4, 3, 2};
  int desc_seq [SEQ_LEN] = '{4, 3, 2, 1, 2, 3};
`else
  localparam int SEQ_LEN = 4;
  int asc_seq  [SEQ_LEN] = '{1, 2, 3, 4};
  int desc_seq [SEQ_LEN] = '{4, 3, 2, 1};
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, dir = 1'b0;
  logic [2:0] sel;
  logic       tick, busy;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: which mode, direction chosen at start, steps taken, RUN cycles since last step.
  int m_mode = M_IDLE, m_dir = 0, m_steps = 0, m_elapsed = 0, m_tick = 0;

  always #5 clk = ~clk;

  light_pattern_seq #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .i_stop  (stop),
    .i_clear (clear),
    .i_dir   (dir),
    .o_select(sel),
    .o_tick  (tick),
    .o_busy  (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_select();
    int idx;
    if (m_mode == M_IDLE) return 0;
    idx = m_steps % SEQ_LEN;
    return (m_dir != 0) ? desc_seq[idx] : asc_seq[idx];
  endfunction

  task automatic model_update(input logic r, input logic s, input logic p, input logic c,
                              input logic d);
    m_tick = 0;
    if (r) begin
      m_mode = M_IDLE; m_dir = 0; m_steps = 0; m_elapsed = 0;
    end else if (m_mode == M_IDLE) begin
      if (s) begin
        m_mode = M_RUN; m_dir = int'(d); m_steps = 0; m_elapsed = 0;
      end
    end else if (m_mode == M_RUN) begin
      if (c) begin
        m_mode = M_IDLE; m_elapsed = 0;
      end else if (p) begin
        m_mode = M_HOLD;
        m_elapsed = (m_elapsed + 1 < CLK_DIV - 1) ? m_elapsed + 1 : CLK_DIV - 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == CLK_DIV) begin
          m_elapsed = 0; m_steps++; m_tick = 1;
        end
      end
    end else begin
      if (c) begin
        m_mode = M_IDLE; m_elapsed = 0;
      end else if (s) begin
        m_mode = M_RUN;
      end
    end
  endtask

  // One clock edge: drive inputs, advance the model, then compare outputs 1 ns after the edge.
  task automatic step(input logic r, input logic s, input logic p, input logic c, input logic d);
    reset = r; start = s; stop = p; clear = c; dir = d;
    @(posedge clk);
    model_update(r, s, p, c, d);
    #1;
    check("select", int'(sel), exp_select());
    check("tick", int'(tick), m_tick);
    check("busy", int'(busy), (m_mode != M_IDLE) ? 1 : 0);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic go_idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step();
  endtask

  initial begin
    int exp_walk [8];
    int exp_asc  [4] = '{2, 3, 4, 1};
    logic rdir;

    // Reset, then stop/clear pulses in IDLE must do nothing.
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_select", int'(sel), 0);
    check("reset_busy", int'(busy), 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_step();
    check("idle_select", int'(sel), 0);
    check("idle_busy", int'(busy), 0);

    // Ascending wrap: start at edge 0, steps at edges 4, 8, 12, 16.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("asc_start", int'(sel), 1);
    for (int e = 1; e <= 16; e++) begin
      idle_step();
      check("asc_tick", int'(tick), (e % 4 == 0) ? 1 : 0);
      if (e % 4 == 0) check("asc_select", int'(sel), exp_asc[e/4-1]);
    end
    go_idle();

    // Pause at edge 2, hold, resume at edge 12, step at edge 14.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 3; e <= 11; e++) begin
      idle_step();
      check("hold_select", int'(sel), 1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_step();
    check("resume_e13", int'(sel), 1);
    idle_step();
    check("resume_e14", int'(sel), 2);
    check("resume_tick", int'(tick), 1);
    go_idle();

    // Stop+start on a terminal-count edge, then clear+start in HOLD.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 3; e++) idle_step();
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("prio_select", int'(sel), 1);
    check("prio_tick", int'(tick), 0);
    check("prio_busy", int'(busy), 1);
    idle_step();
    idle_step();
    check("prio_hold", int'(sel), 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("prio_clear", int'(sel), 0);
    check("prio_clear_busy", int'(busy), 0);
    idle_step();

    // Seven steps: descending wrap, or ascending ping-pong.
`ifdef LIGHT_SEQ_BOUNCE_EN
    rdir = 1'b0;
    exp_walk = '{1, 2, 3, 4, 3, 2, 1, 2};
`else
    rdir = 1'b1;
    exp_walk = '{4, 3, 2, 1, 4, 3, 2, 1};
`endif
    step(1'b0, 1'b1, 1'b0, 1'b0, rdir);
    check("walk_0", int'(sel), exp_walk[0]);
    for (int e = 1; e <= 28; e++) begin
      idle_step();
      if (e % 4 == 0) check("walk", int'(sel), exp_walk[e/4]);
    end
    go_idle();

    // Reset at edge 6 of a run, then a clean restart with the full delay.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 5; e++) idle_step();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_run_select", int'(sel), 0);
    check("rst_run_busy", int'(busy), 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_select", int'(sel), 1);
    for (int e = 1; e <= 3; e++) begin
      idle_step();
      check("restart_wait", int'(sel), 1);
    end
    idle_step();
    check("restart_step", int'(sel), 2);

    // Random control pulses checked against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(5) == 0), ($urandom_range(9) == 0),
           ($urandom_range(19) == 0), 1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
